// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with single-cycle logic/arith ops and a
// serial one-bit-per-cycle shifter behind a start/busy/done handshake.
module alu_exec_unit #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [3:0]         ALUCtrl_i,
   input  logic [DATA_W-1:0]  src1_i,
   input  logic [DATA_W-1:0]  src2_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [DATA_W-1:0]  result_o,
   output logic               zero_o,
   output logic               overflow_o
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state_q, state_d;
   logic [DATA_W-1:0] sh_q, sh_d, res_q, res_d, sum, diff, alu_res, sh_next;
   logic [SHAMT_W-1:0] cnt_q, cnt_d, amt;
   logic left_q, left_d, fill_q, fill_d, zero_q, zero_d, ovf_q, ovf_d;
   logic alu_ovf, is_shift;
   assign sum      = src1_i + src2_i;
   assign diff     = src1_i - src2_i;
   assign is_shift = ALUCtrl_i inside {4'b0000, 4'b0010, 4'b0011, 4'b0100, 4'b0111};
   assign amt      = (ALUCtrl_i == 4'b0100 || ALUCtrl_i == 4'b0111) ? src1_i[SHAMT_W-1:0] : shamt_i;
   assign sh_next  = left_q ? {sh_q[DATA_W-2:0], 1'b0} : {fill_q, sh_q[DATA_W-1:1]};
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (ALUCtrl_i)
         4'b1001: begin
            alu_res = sum;
            alu_ovf = (src1_i[DATA_W-1] == src2_i[DATA_W-1]) && (sum[DATA_W-1] != src1_i[DATA_W-1]);
         end
         4'b1011: begin
            alu_res = diff;
            alu_ovf = (src1_i[DATA_W-1] != src2_i[DATA_W-1]) && (diff[DATA_W-1] != src1_i[DATA_W-1]);
         end
         4'b1100: alu_res = src1_i & src2_i;
         4'b1101, 4'b0110: alu_res = src1_i | src2_i;
         4'b1110: alu_res = src1_i ^ src2_i;
         4'b1010: alu_res = DATA_W'($signed(src1_i) < $signed(src2_i));
         4'b0101: alu_res = DATA_W'(src1_i < src2_i);
         4'b1111: alu_res = src2_i << 16;
         4'b0001: alu_res = src2_i;
         default: alu_res = '0;
      endcase
   end
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      left_d  = left_q;
      fill_d  = fill_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: if (start_i) begin
            if (!is_shift) begin
               res_d   = alu_res;
               zero_d  = alu_res == '0;
               ovf_d   = alu_ovf;
               state_d = DONE;
            end else if (amt == '0) begin
               res_d   = src2_i;
               zero_d  = src2_i == '0;
               ovf_d   = 1'b0;
               state_d = DONE;
            end else begin
               sh_d    = src2_i;
               cnt_d   = amt;
               left_d  = ALUCtrl_i == 4'b0000 || ALUCtrl_i == 4'b0100;
               fill_d  = (ALUCtrl_i == 4'b0011 || ALUCtrl_i == 4'b0111) && src2_i[DATA_W-1];
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sh_d  = sh_next;
            cnt_d = cnt_q - 1'b1;
            // last shift step: publish the shifted value directly
            if (cnt_q == 1) begin
               res_d   = sh_next;
               zero_d  = sh_next == '0;
               ovf_d   = 1'b0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
         left_q  <= 1'b0;
         fill_q  <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b1;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         left_q  <= left_d;
         fill_q  <= fill_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
      end
   end
   assign busy_o     = state_q == SHIFT;
   assign done_o     = state_q == DONE;
   assign result_o   = res_q;
   assign zero_o     = zero_q;
   assign overflow_o = ovf_q;
endmodule
